// File: rtl/dma_pkg.sv
// Shared constants and FSM encoding for the DMA channel scheduler.
package dma_pkg;

  localparam int PRIO_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/dma_prio_rr_pick.sv
// Combinational winner selection: highest priority among eligible channels,
// ties resolved round-robin starting one past rr_ptr.
module dma_prio_rr_pick
  import dma_pkg::*;
#(
  parameter int channel_number      = 31,
  parameter int channel_number_bits = $clog2(channel_number)
) (
  input  logic [channel_number-1:0]      eligible,
  input  logic [PRIO_W-1:0]              ch_prio [0:channel_number-1],
  input  logic [channel_number_bits-1:0] rr_ptr,
  output logic                           found,
  output logic [channel_number_bits-1:0] win_id
);

  logic [PRIO_W-1:0]         max_prio;
  logic [channel_number-1:0] top_mask;

  always_comb begin
    max_prio = '0;
    for (int k = 0; k < channel_number; k++) begin
      if (eligible[k] && (ch_prio[k] > max_prio)) begin
        max_prio = ch_prio[k];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < channel_number; gi++) begin : g_top
      assign top_mask[gi] = eligible[gi] && (ch_prio[gi] == max_prio);
    end
  endgenerate

  // rr_ptr + i stays below 2*channel_number, so one conditional subtract wraps it.
  always_comb begin
    logic [channel_number_bits:0] idx;
    found  = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int i = 1; i <= channel_number; i++) begin
      idx = {1'b0, rr_ptr} + (channel_number_bits + 1)'(i);
      if (idx >= (channel_number_bits + 1)'(channel_number)) begin
        idx = idx - (channel_number_bits + 1)'(channel_number);
      end
      if (!found && top_mask[idx[channel_number_bits-1:0]]) begin
        found  = 1'b1;
        win_id = idx[channel_number_bits-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_ch_scheduler.sv
// DMA channel scheduler: non-pre-emptive priority arbitration with round-robin
// tie-break, registered one-hot grant, and abort when a granted channel is disabled.
module dma_ch_scheduler
  import dma_pkg::*;
#(
  parameter int channel_number      = 31,
  parameter int channel_number_bits = $clog2(channel_number)
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic [channel_number-1:0]      ch_req,
  input  logic [channel_number-1:0]      ch_en,
  input  logic [PRIO_W-1:0]              ch_prio [0:channel_number-1],
  input  logic                           eng_idle,
  input  logic [channel_number-1:0]      ch_done,
  output logic [channel_number-1:0]      grant,
  output logic                           grant_valid,
  output logic [channel_number_bits-1:0] grant_id,
  output logic                           abort
);

  sched_state_t                   state_reg, state_next;
  logic [channel_number-1:0]      grant_reg, grant_next;
  logic                           grant_valid_reg, grant_valid_next;
  logic [channel_number_bits-1:0] grant_id_reg, grant_id_next;
  logic                           abort_reg, abort_next;
  logic [channel_number_bits-1:0] rr_ptr_reg, rr_ptr_next;

  logic [channel_number-1:0]      eligible;
  logic                           found;
  logic [channel_number_bits-1:0] win_id;

  genvar gi;
  generate
    for (gi = 0; gi < channel_number; gi++) begin : g_elig
      assign eligible[gi] = ch_en[gi] & ch_req[gi];
    end
  endgenerate

  dma_prio_rr_pick #(
    .channel_number      (channel_number),
    .channel_number_bits (channel_number_bits)
  ) u_pick (
    .eligible (eligible),
    .ch_prio  (ch_prio),
    .rr_ptr   (rr_ptr_reg),
    .found    (found),
    .win_id   (win_id)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg       <= ST_IDLE;
      grant_reg       <= '0;
      grant_valid_reg <= 1'b0;
      grant_id_reg    <= '0;
      abort_reg       <= 1'b0;
      rr_ptr_reg      <= channel_number_bits'(channel_number - 1);
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      grant_valid_reg <= grant_valid_next;
      grant_id_reg    <= grant_id_next;
      abort_reg       <= abort_next;
      rr_ptr_reg      <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    grant_valid_next = grant_valid_reg;
    grant_id_next    = grant_id_reg;
    abort_next       = 1'b0;
    rr_ptr_next      = rr_ptr_reg;

    case (state_reg)
      ST_IDLE: begin
        if (eng_idle && found) begin
          grant_next       = {{(channel_number - 1){1'b0}}, 1'b1} << win_id;
          grant_valid_next = 1'b1;
          grant_id_next    = win_id;
          state_next       = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Done takes precedence over a simultaneous disable: no abort in that case.
        if (ch_done[grant_id_reg]) begin
          grant_next       = '0;
          grant_valid_next = 1'b0;
          state_next       = ST_RELEASE;
        end else if (!ch_en[grant_id_reg]) begin
          grant_next       = '0;
          grant_valid_next = 1'b0;
          abort_next       = 1'b1;
          state_next       = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        rr_ptr_next = grant_id_reg;
        state_next  = ST_IDLE;
      end
      default: begin
        grant_next       = '0;
        grant_valid_next = 1'b0;
        state_next       = ST_IDLE;
      end
    endcase
  end

  assign grant       = grant_reg;
  assign grant_valid = grant_valid_reg;
  assign grant_id    = grant_id_reg;
  assign abort       = abort_reg;

endmodule

// File: tb/tb_dma_ch_scheduler.sv
// Self-checking bench for dma_ch_scheduler: directed scenarios followed by
// randomized traffic, all compared every cycle against a transaction-level model.
module tb_dma_ch_scheduler;

  localparam int N = 31;
  localparam int B = $clog2(N);

  logic         HCLK;
  logic         HRESETn;
  logic [N-1:0] ch_req;
  logic [N-1:0] ch_en;
  logic [2:0]   ch_prio [0:N-1];
  logic         eng_idle;
  logic [N-1:0] ch_done;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [B-1:0] grant_id;
  logic         abort;

  int vectors;
  int miscompares;

  // Model: who holds the grant, who last held it, whether the post-release gap is pending.
  int m_holder;
  int m_last;
  int m_id;
  bit m_gap;
  bit m_abort;

  dma_ch_scheduler #(
    .channel_number      (N),
    .channel_number_bits (B)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .ch_req      (ch_req),
    .ch_en       (ch_en),
    .ch_prio     (ch_prio),
    .eng_idle    (eng_idle),
    .ch_done     (ch_done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .abort       (abort)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic int ref_pick();
    for (int p = 7; p >= 0; p--) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (m_last + i) % N;
        if (ch_en[k] && ch_req[k] && (int'(ch_prio[k]) == p)) return k;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_last   = N - 1;
    m_id     = 0;
    m_gap    = 1'b0;
    m_abort  = 1'b0;
  endtask

  task automatic model_step();
    int w;
    if (!HRESETn) begin
      model_reset();
      return;
    end
    m_abort = 1'b0;
    if (m_holder >= 0) begin
      if (ch_done[m_holder]) begin
        m_last = m_holder; m_holder = -1; m_gap = 1'b1;
      end else if (!ch_en[m_holder]) begin
        m_last = m_holder; m_holder = -1; m_gap = 1'b1; m_abort = 1'b1;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (eng_idle) begin
      w = ref_pick();
      if (w >= 0) begin
        m_holder = w;
        m_id     = w;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_grant;
    exp_grant = (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0;
    chk("grant",       32'(grant),       exp_grant);
    chk("grant_valid", 32'(grant_valid), (m_holder >= 0) ? 32'd1 : 32'd0);
    chk("grant_id",    32'(grant_id),    32'(m_id));
    chk("abort",       32'(abort),       32'(m_abort));
  endtask

  task automatic cycle();
    @(posedge HCLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    model_reset();
    #1;
    check_all();
    cycle();
    cycle();
    HRESETn = 1'b1;
  endtask

  task automatic wait_grant(input int exp, input string tag);
    int n;
    n = 0;
    while (!grant_valid && n < 10) begin
      cycle();
      n++;
    end
    chk({tag, "_valid"}, 32'(grant_valid), 32'd1);
    chk({tag, "_id"},    32'(grant_id),    32'(exp));
  endtask

  task automatic pulse_done();
    if (m_holder >= 0) ch_done[m_holder] = 1'b1;
    cycle();
    ch_done = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    HRESETn     = 1'b0;
    ch_req      = '0;
    ch_en       = '1;
    ch_done     = '0;
    eng_idle    = 1'b1;
    for (int k = 0; k < N; k++) ch_prio[k] = 3'd0;
    model_reset();
    #1;
    check_all();
    cycle();
    HRESETn = 1'b1;
    cycle();

    // Single request: grant exactly one cycle after it appears.
    ch_req[3]  = 1'b1;
    ch_prio[3] = 3'd2;
    cycle();
    chk("single_grant", 32'(grant), 32'h8);
    chk("single_id",    32'(grant_id), 32'd3);
    ch_req = '0;
    pulse_done();
    cycle();

    // Equal priority round-robin with wrap.
    do_reset();
    ch_req[2] = 1'b1; ch_req[5] = 1'b1; ch_req[9] = 1'b1;
    ch_prio[2] = 3'd4; ch_prio[5] = 3'd4; ch_prio[9] = 3'd4;
    wait_grant(2, "rr0"); pulse_done();
    wait_grant(5, "rr1"); pulse_done();
    wait_grant(9, "rr2"); pulse_done();
    wait_grant(2, "rr3");
    ch_req = '0;
    pulse_done();
    cycle();

    // Priority ordering and no pre-emption.
    do_reset();
    ch_req[1] = 1'b1; ch_prio[1] = 3'd1;
    ch_req[7] = 1'b1; ch_prio[7] = 3'd6;
    wait_grant(7, "prio_first");
    ch_req[12] = 1'b1; ch_prio[12] = 3'd7;
    repeat (3) cycle();
    chk("no_preempt", 32'(grant), 32'd1 << 7);
    ch_req[7] = 1'b0;
    pulse_done();
    wait_grant(12, "prio_next");
    ch_req = '0;
    pulse_done();
    repeat (2) cycle();

    // Abort on disable of granted channel.
    ch_req[4] = 1'b1; ch_prio[4] = 3'd3;
    wait_grant(4, "abort_pre");
    ch_req[4] = 1'b0;
    ch_en[4]  = 1'b0;
    cycle();
    chk("abort_pulse", 32'(abort), 32'd1);
    chk("abort_drop",  32'(grant), 32'd0);
    ch_en[4] = 1'b1;
    cycle();
    chk("abort_once", 32'(abort), 32'd0);
    cycle();

    // Foreign done ignored; done together with disable is not an abort.
    ch_req[4] = 1'b1;
    wait_grant(4, "done_pre");
    ch_done[6] = 1'b1;
    cycle();
    ch_done = '0;
    chk("foreign_done", 32'(grant), 32'd1 << 4);
    ch_req[4] = 1'b0;
    ch_done[4] = 1'b1;
    ch_en[4]   = 1'b0;
    cycle();
    ch_done = '0;
    ch_en   = '1;
    chk("done_wins_abort", 32'(abort), 32'd0);
    chk("done_wins_grant", 32'(grant), 32'd0);
    repeat (2) cycle();

    // Asynchronous reset while granted; next search restarts from channel 0.
    ch_req[4] = 1'b1;
    wait_grant(4, "rst_pre");
    ch_req = '0;
    ch_req[0] = 1'b1; ch_prio[0] = 3'd5;
    ch_req[5] = 1'b1; ch_prio[5] = 3'd5;
    do_reset();
    wait_grant(0, "rst_post");
    ch_req = '0;
    pulse_done();
    cycle();

    // Randomized traffic.
    for (int it = 0; it < 600; it++) begin
      eng_idle = ($urandom_range(0, 3) != 0);
      ch_en    = ~(N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom));
      ch_req   = N'($urandom) & N'($urandom);
      for (int k = 0; k < N; k++) ch_prio[k] = 3'($urandom_range(0, 7));
      ch_done  = N'($urandom) & N'($urandom) & N'($urandom);
      if (m_holder >= 0 && $urandom_range(0, 3) == 0) ch_done[m_holder] = 1'b1;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_ch_scheduler.md
DMA_CH_SCHEDULER -- requirements
Module: dma_ch_scheduler

Interface
REQ-001 SHALL have parameter channel_number, default 31, number of DMA channels.
REQ-002 SHALL have parameter channel_number_bits, default $clog2(channel_number), width of channel index.
REQ-003 SHALL have port HCLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ch_req  input  channel_number  per-channel transfer request (from request arbiter).
REQ-006 SHALL have port ch_en  input  channel_number  per-channel enable (CSR bit 0).
REQ-007 SHALL have port ch_prio  input  3 x channel_number (unpacked [0:channel_number-1])  per-channel priority, 7 highest.
REQ-008 SHALL have port eng_idle  input  1  transfer engine idle; arbitration permitted only when high.
REQ-009 SHALL have port ch_done  input  channel_number  one-cycle pulse, transfer finished, from the active channel.
REQ-010 SHALL have port grant  output  channel_number  one-hot grant, registered.
REQ-011 SHALL have port grant_valid  output  1  high while any grant is held.
REQ-012 SHALL have port grant_id  output  channel_number_bits  index of granted channel; holds last value when grant_valid low.
REQ-013 SHALL have port abort  output  1  one-cycle pulse when a held grant is revoked by ch_en falling.

Function
REQ-014 Eligible channel: ch_en[k] & ch_req[k].
REQ-015 FSM states: IDLE, GRANT, RELEASE.
REQ-016 IDLE: if eng_idle and at least one eligible channel, register winner -> grant, grant_valid, grant_id valid the next cycle (1-cycle latency); state -> GRANT.
REQ-017 Winner: highest ch_prio among eligible; ties broken round-robin, search starting at rr_ptr+1, wrapping channel_number-1 -> 0.
REQ-018 GRANT: grant held stable regardless of ch_req changes or higher-priority requests (no pre-emption).
REQ-019 GRANT exit: ch_done[grant_id]=1 -> RELEASE; ch_en[grant_id]=0 -> RELEASE plus abort pulse in the same cycle grant drops.
REQ-020 Simultaneous ch_done and ch_en fall on the granted channel: treated as done, no abort.
REQ-021 ch_done on a non-granted channel SHALL be ignored.
REQ-022 RELEASE: grant=0, grant_valid=0 for exactly one cycle; rr_ptr <- grant_id; state -> IDLE.
REQ-023 Minimum gap between consecutive grants: 1 cycle (RELEASE) plus IDLE arbitration cycle.
REQ-024 eng_idle low in IDLE: no grant issued; eligibility re-evaluated every cycle.
REQ-025 grant SHALL be one-hot or zero at all times; grant_valid == |grant.

Reset
REQ-026 On HRESETn low: state=IDLE, grant=0, grant_valid=0, grant_id=0, abort=0, rr_ptr=channel_number-1 (first search starts at channel 0).
REQ-027 Reset mid-GRANT SHALL drop grant immediately (asynchronous) without abort pulse.

Structure
REQ-028 State enum and PRIO_W=3 constant SHALL live in shared package dma_pkg.
REQ-029 Combinational winner selection SHALL be sub-module dma_prio_rr_pick (inputs eligible, ch_prio, rr_ptr; outputs found, win_id).
REQ-030 All outputs SHALL be driven from flops; no combinational path from ch_req to grant.

Verification
REQ-031 Reset, eng_idle=1, ch_en=all, ch_req[3]=1 prio 2 -> grant=1<<3, grant_id=3 one cycle after request.
REQ-032 ch_req[2],[5],[9] all prio 4, each granted then done -> grant order 2,5,9,2 (round-robin wrap).
REQ-033 ch_req[1] prio 1, ch_req[7] prio 6 -> channel 7 first; ch_req[12] prio 7 raised during grant of 7 -> no pre-emption, 12 next.
REQ-034 Grant to 4, ch_en[4] drops -> abort=1 one cycle, grant=0 next cycle, RELEASE, then IDLE.
REQ-035 ch_done[6] pulse while channel 4 granted -> grant unchanged; simultaneous ch_done[4]&ch_en[4] fall -> no abort.
REQ-036 HRESETn asserted during GRANT -> grant=0 immediately, grant_id=0, first post-reset grant searches from channel 0.
